// File: rtl/ahb_dual_arbiter.sv
// Two-master AHB-Lite arbiter: the instruction and data buses share one slave port.
// Each master has a one-entry address-phase buffer, so a transfer that loses arbitration is replayed later.
module ahb_dual_arbiter #(
    parameter int unsigned DATA_PRIO = 1
) (
    input  logic        s_clk_i,
    input  logic        s_resetn_i,
    // instruction master
    input  logic [31:0] s_i_haddr_i,
    input  logic [31:0] s_i_hwdata_i,
    input  logic [1:0]  s_i_htrans_i,
    input  logic [2:0]  s_i_hsize_i,
    input  logic [2:0]  s_i_hburst_i,
    input  logic [3:0]  s_i_hprot_i,
    input  logic        s_i_hwrite_i,
    input  logic        s_i_hmastlock_i,
    input  logic [6:0]  s_i_hwchecksum_i,
    input  logic [5:0]  s_i_hparity_i,
    output logic [31:0] s_i_hrdata_o,
    output logic [6:0]  s_i_hrchecksum_o,
    output logic        s_i_hready_o,
    output logic        s_i_hresp_o,
    // data master
    input  logic [31:0] s_d_haddr_i,
    input  logic [31:0] s_d_hwdata_i,
    input  logic [1:0]  s_d_htrans_i,
    input  logic [2:0]  s_d_hsize_i,
    input  logic [2:0]  s_d_hburst_i,
    input  logic [3:0]  s_d_hprot_i,
    input  logic        s_d_hwrite_i,
    input  logic        s_d_hmastlock_i,
    input  logic [6:0]  s_d_hwchecksum_i,
    input  logic [5:0]  s_d_hparity_i,
    output logic [31:0] s_d_hrdata_o,
    output logic [6:0]  s_d_hrchecksum_o,
    output logic        s_d_hready_o,
    output logic        s_d_hresp_o,
    // shared slave port
    output logic [31:0] s_m_haddr_o,
    output logic [31:0] s_m_hwdata_o,
    output logic [1:0]  s_m_htrans_o,
    output logic [2:0]  s_m_hsize_o,
    output logic [2:0]  s_m_hburst_o,
    output logic [3:0]  s_m_hprot_o,
    output logic        s_m_hwrite_o,
    output logic        s_m_hmastlock_o,
    output logic [6:0]  s_m_hwchecksum_o,
    output logic [5:0]  s_m_hparity_o,
    input  logic [31:0] s_m_hrdata_i,
    input  logic [6:0]  s_m_hrchecksum_i,
    input  logic        s_m_hready_i,
    input  logic        s_m_hresp_i,
    output logic [1:0]  s_owner_o
);

    typedef enum logic [1:0] {ST_IDLE, ST_PEND, ST_DATA} stage_e;
    typedef enum logic [2:0] {GNT_NONE, GNT_I_LIVE, GNT_I_BUF, GNT_D_LIVE, GNT_D_BUF} grant_e;

    typedef struct packed {
        logic [31:0] haddr;
        logic [1:0]  htrans;
        logic [2:0]  hsize;
        logic [2:0]  hburst;
        logic [3:0]  hprot;
        logic        hwrite;
        logic        hmastlock;
        logic [5:0]  hparity;
    } aphase_t;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_I    = 2'd1;
    localparam logic [1:0] OWN_D    = 2'd2;
    localparam bit         PRIO_D   = (DATA_PRIO != 0);

    stage_e     i_state_q, i_state_d, d_state_q, d_state_d;
    aphase_t    i_buf_q, i_buf_d, d_buf_q, d_buf_d;
    grant_e     grant_q, grant_d;
    logic [1:0] owner_q, owner_d;
    logic       lock_q, lock_d;
    logic       lock_on_d_q, lock_on_d_d;

    aphase_t    i_live, d_live, m_aphase;
    grant_e     grant_arb, grant_sel;
    logic       i_hready, d_hready;
    logic       i_live_req, d_live_req;
    logic       i_buf_ok, d_buf_ok, i_live_ok, d_live_ok;
    logic       i_granted, d_granted, i_capture, d_capture;

    assign i_live = '{haddr: s_i_haddr_i, htrans: s_i_htrans_i, hsize: s_i_hsize_i,
                      hburst: s_i_hburst_i, hprot: s_i_hprot_i, hwrite: s_i_hwrite_i,
                      hmastlock: s_i_hmastlock_i, hparity: s_i_hparity_i};
    assign d_live = '{haddr: s_d_haddr_i, htrans: s_d_htrans_i, hsize: s_d_hsize_i,
                      hburst: s_d_hburst_i, hprot: s_d_hprot_i, hwrite: s_d_hwrite_i,
                      hmastlock: s_d_hmastlock_i, hparity: s_d_hparity_i};

    function automatic stage_e stage_next(input stage_e cur, input logic granted,
                                          input logic capture, input logic ready);
        stage_e nxt;
        nxt = cur;
        if (granted)
            nxt = ST_DATA;
        else if (capture)
            nxt = ST_PEND;
        else if (cur == ST_DATA && ready)
            nxt = ST_IDLE;
        return nxt;
    endfunction

    // A live request only exists while the master itself sees hready high.
    always_comb begin
        i_hready   = (i_state_q == ST_DATA) ? s_m_hready_i : (i_state_q != ST_PEND);
        d_hready   = (d_state_q == ST_DATA) ? s_m_hready_i : (d_state_q != ST_PEND);
        i_live_req = s_resetn_i && s_i_htrans_i[1] && i_hready;
        d_live_req = s_resetn_i && s_d_htrans_i[1] && d_hready;
    end

    // NOTE: every signal written in a combinational block gets a default first, otherwise a latch is inferred.
    always_comb begin
        grant_arb = GNT_NONE;
        i_buf_ok  = (i_state_q == ST_PEND) && (!lock_q || !lock_on_d_q);
        d_buf_ok  = (d_state_q == ST_PEND) && (!lock_q ||  lock_on_d_q);
        i_live_ok = i_live_req && (!lock_q || !lock_on_d_q);
        d_live_ok = d_live_req && (!lock_q ||  lock_on_d_q);

        if (!s_resetn_i)
            grant_arb = GNT_NONE;
        else if (i_buf_ok && d_buf_ok) begin
            if (PRIO_D) grant_arb = GNT_D_BUF;
            else        grant_arb = GNT_I_BUF;
        end
        else if (i_buf_ok)
            grant_arb = GNT_I_BUF;
        else if (d_buf_ok)
            grant_arb = GNT_D_BUF;
        else if (i_live_ok && d_live_ok) begin
            if (PRIO_D) grant_arb = GNT_D_LIVE;
            else        grant_arb = GNT_I_LIVE;
        end
        else if (i_live_ok)
            grant_arb = GNT_I_LIVE;
        else if (d_live_ok)
            grant_arb = GNT_D_LIVE;

        if (!s_resetn_i)
            grant_sel = GNT_NONE;
        else if (s_m_hready_i)
            grant_sel = grant_arb;
        else
            grant_sel = grant_q;

        m_aphase = '0;
        case (grant_sel)
            GNT_I_LIVE: m_aphase = i_live;
            GNT_I_BUF:  m_aphase = i_buf_q;
            GNT_D_LIVE: m_aphase = d_live;
            GNT_D_BUF:  m_aphase = d_buf_q;
            default:    m_aphase = '0;
        endcase
    end

    always_comb begin
        i_granted = s_m_hready_i && (grant_arb == GNT_I_LIVE || grant_arb == GNT_I_BUF);
        d_granted = s_m_hready_i && (grant_arb == GNT_D_LIVE || grant_arb == GNT_D_BUF);
        i_capture = i_live_req && !(s_m_hready_i && grant_arb == GNT_I_LIVE);
        d_capture = d_live_req && !(s_m_hready_i && grant_arb == GNT_D_LIVE);

        i_state_d = stage_next(i_state_q, i_granted, i_capture, s_m_hready_i);
        d_state_d = stage_next(d_state_q, d_granted, d_capture, s_m_hready_i);
        i_buf_d   = i_capture ? i_live : i_buf_q;
        d_buf_d   = d_capture ? d_live : d_buf_q;

        grant_d     = grant_q;
        owner_d     = owner_q;
        lock_d      = lock_q;
        lock_on_d_d = lock_on_d_q;
        if (s_m_hready_i) begin
            grant_d = grant_arb;
            owner_d = i_granted ? OWN_I : (d_granted ? OWN_D : OWN_NONE);
            // An idle cycle keeps the lock only while the holder still drives hmastlock.
            if (grant_arb != GNT_NONE) begin
                lock_d      = m_aphase.hmastlock;
                lock_on_d_d = d_granted;
            end else begin
                lock_d = lock_q && (lock_on_d_q ? s_d_hmastlock_i : s_i_hmastlock_i);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; blocking here would race with other flops.
    always_ff @(posedge s_clk_i) begin
        if (!s_resetn_i) begin
            i_state_q   <= ST_IDLE;
            d_state_q   <= ST_IDLE;
            i_buf_q     <= '0;
            d_buf_q     <= '0;
            grant_q     <= GNT_NONE;
            owner_q     <= OWN_NONE;
            lock_q      <= 1'b0;
            lock_on_d_q <= 1'b0;
        end else begin
            i_state_q   <= i_state_d;
            d_state_q   <= d_state_d;
            i_buf_q     <= i_buf_d;
            d_buf_q     <= d_buf_d;
            grant_q     <= grant_d;
            owner_q     <= owner_d;
            lock_q      <= lock_d;
            lock_on_d_q <= lock_on_d_d;
        end
    end

    assign s_m_haddr_o     = m_aphase.haddr;
    assign s_m_htrans_o    = m_aphase.htrans;
    assign s_m_hsize_o     = m_aphase.hsize;
    assign s_m_hburst_o    = m_aphase.hburst;
    assign s_m_hprot_o     = m_aphase.hprot;
    assign s_m_hwrite_o    = m_aphase.hwrite;
    assign s_m_hmastlock_o = m_aphase.hmastlock;
    assign s_m_hparity_o   = m_aphase.hparity;

    // Write data and its checksum follow the data-phase owner, not the address-phase grant.
    assign s_m_hwdata_o     = (owner_q == OWN_D) ? s_d_hwdata_i :
                              (owner_q == OWN_I) ? s_i_hwdata_i : '0;
    assign s_m_hwchecksum_o = (owner_q == OWN_D) ? s_d_hwchecksum_i :
                              (owner_q == OWN_I) ? s_i_hwchecksum_i : '0;

    assign s_i_hrdata_o     = s_m_hrdata_i;
    assign s_d_hrdata_o     = s_m_hrdata_i;
    assign s_i_hrchecksum_o = s_m_hrchecksum_i;
    assign s_d_hrchecksum_o = s_m_hrchecksum_i;
    assign s_i_hready_o     = i_hready;
    assign s_d_hready_o     = d_hready;
    assign s_i_hresp_o      = s_m_hresp_i && (owner_q == OWN_I);
    assign s_d_hresp_o      = s_m_hresp_i && (owner_q == OWN_D);
    assign s_owner_o        = owner_q;

endmodule

// File: tb/tb_ahb_dual_arbiter.sv
// Directed bench for ahb_dual_arbiter: inputs change on the falling edge, outputs are checked 1 ns later.
module tb_ahb_dual_arbiter;

    logic        clk;
    logic        resetn;
    logic [31:0] i_haddr, i_hwdata, d_haddr, d_hwdata;
    logic [1:0]  i_htrans, d_htrans;
    logic [2:0]  i_hsize, i_hburst, d_hsize, d_hburst;
    logic [3:0]  i_hprot, d_hprot;
    logic        i_hwrite, i_hlock, d_hwrite, d_hlock;
    logic [6:0]  i_hwchk, d_hwchk;
    logic [5:0]  i_hpar, d_hpar;
    logic [31:0] i_hrdata, d_hrdata;
    logic [6:0]  i_hrchk, d_hrchk;
    logic        i_hready, i_hresp, d_hready, d_hresp;
    logic [31:0] m_haddr, m_hwdata, m_hrdata;
    logic [1:0]  m_htrans;
    logic [2:0]  m_hsize, m_hburst;
    logic [3:0]  m_hprot;
    logic        m_hwrite, m_hlock, m_hready, m_hresp;
    logic [6:0]  m_hwchk, m_hrchk;
    logic [5:0]  m_hpar;
    logic [1:0]  owner;

    int total = 0;
    int bad   = 0;

    ahb_dual_arbiter #(.DATA_PRIO(1)) dut (
        .s_clk_i(clk), .s_resetn_i(resetn),
        .s_i_haddr_i(i_haddr), .s_i_hwdata_i(i_hwdata), .s_i_htrans_i(i_htrans),
        .s_i_hsize_i(i_hsize), .s_i_hburst_i(i_hburst), .s_i_hprot_i(i_hprot),
        .s_i_hwrite_i(i_hwrite), .s_i_hmastlock_i(i_hlock), .s_i_hwchecksum_i(i_hwchk),
        .s_i_hparity_i(i_hpar), .s_i_hrdata_o(i_hrdata), .s_i_hrchecksum_o(i_hrchk),
        .s_i_hready_o(i_hready), .s_i_hresp_o(i_hresp),
        .s_d_haddr_i(d_haddr), .s_d_hwdata_i(d_hwdata), .s_d_htrans_i(d_htrans),
        .s_d_hsize_i(d_hsize), .s_d_hburst_i(d_hburst), .s_d_hprot_i(d_hprot),
        .s_d_hwrite_i(d_hwrite), .s_d_hmastlock_i(d_hlock), .s_d_hwchecksum_i(d_hwchk),
        .s_d_hparity_i(d_hpar), .s_d_hrdata_o(d_hrdata), .s_d_hrchecksum_o(d_hrchk),
        .s_d_hready_o(d_hready), .s_d_hresp_o(d_hresp),
        .s_m_haddr_o(m_haddr), .s_m_hwdata_o(m_hwdata), .s_m_htrans_o(m_htrans),
        .s_m_hsize_o(m_hsize), .s_m_hburst_o(m_hburst), .s_m_hprot_o(m_hprot),
        .s_m_hwrite_o(m_hwrite), .s_m_hmastlock_o(m_hlock), .s_m_hwchecksum_o(m_hwchk),
        .s_m_hparity_o(m_hpar), .s_m_hrdata_i(m_hrdata), .s_m_hrchecksum_i(m_hrchk),
        .s_m_hready_i(m_hready), .s_m_hresp_i(m_hresp), .s_owner_o(owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic drv_i(input logic [1:0] tr, input logic [31:0] a, input logic wr,
                         input logic lk, input logic [5:0] par);
        i_htrans = tr; i_haddr = a; i_hwrite = wr; i_hlock = lk; i_hpar = par;
    endtask

    task automatic drv_d(input logic [1:0] tr, input logic [31:0] a, input logic wr,
                         input logic lk, input logic [5:0] par);
        d_htrans = tr; d_haddr = a; d_hwrite = wr; d_hlock = lk; d_hpar = par;
    endtask

    // Back-to-back data traffic with one instruction request (columns are per cycle).
    logic [31:0] st_d_addr [10] = '{32'h1000, 32'h1004, 32'h1008, 32'h100C, 32'h100C,
                                    32'h1010, 32'h1014, 32'h1018, 32'h101C, 32'h0};
    logic [31:0] st_i_addr [10] = '{32'h0, 32'h800, 32'h0, 32'h0, 32'h0,
                                    32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    logic [31:0] st_m_addr [10] = '{32'h1000, 32'h1004, 32'h800, 32'h1008, 32'h100C,
                                    32'h1010, 32'h1014, 32'h1018, 32'h101C, 32'h0};
    logic        st_d_rdy  [10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic        st_i_rdy  [10] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [1:0]  st_owner  [10] = '{2'd0, 2'd2, 2'd2, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2};

    initial begin
        int stalls;
        resetn = 1'b0;
        drv_i(2'b00, 32'h0, 1'b0, 1'b0, 6'h0);
        drv_d(2'b00, 32'h0, 1'b0, 1'b0, 6'h0);
        i_hsize = 3'd2; i_hburst = 3'd0; i_hprot = 4'h3; i_hwdata = '0; i_hwchk = '0;
        d_hsize = 3'd2; d_hburst = 3'd0; d_hprot = 4'h3; d_hwdata = '0; d_hwchk = '0;
        m_hready = 1'b1; m_hresp = 1'b0; m_hrdata = '0; m_hrchk = '0;
        repeat (2) @(posedge clk);

        // Reset state
        @(negedge clk); #1;
        check("rst_htrans", 32'(m_htrans), 0);
        check("rst_haddr", m_haddr, 0);
        check("rst_hwdata", m_hwdata, 0);
        check("rst_i_hready", 32'(i_hready), 1);
        check("rst_d_hready", 32'(d_hready), 1);
        check("rst_owner", 32'(owner), 0);

        // Single master read, zero wait states
        @(negedge clk);
        resetn = 1'b1;
        drv_d(2'b10, 32'h100, 1'b0, 1'b0, 6'h2A);
        #1;
        check("single_addr", m_haddr, 32'h100);
        check("single_htrans", 32'(m_htrans), 2);
        check("single_parity", 32'(m_hpar), 32'h2A);
        check("single_hsize", 32'(m_hsize), 2);
        check("single_hprot", 32'(m_hprot), 3);
        check("single_i_rdy0", 32'(i_hready), 1);
        @(negedge clk);
        drv_d(2'b00, 32'h0, 1'b0, 1'b0, 6'h0);
        m_hrdata = 32'hCAFE_0001; m_hrchk = 7'h11;
        #1;
        check("single_d_rdata", d_hrdata, 32'hCAFE_0001);
        check("single_i_rdata", i_hrdata, 32'hCAFE_0001);
        check("single_d_rchk", 32'(d_hrchk), 32'h11);
        check("single_i_rchk", 32'(i_hrchk), 32'h11);
        check("single_owner", 32'(owner), 2);
        check("single_i_rdy1", 32'(i_hready), 1);
        check("single_idle", 32'(m_htrans), 0);
        @(negedge clk);
        m_hrdata = '0; m_hrchk = '0;
        #1;
        check("single_owner_end", 32'(owner), 0);

        // Collision: data wins, instruction replayed from its buffer
        @(negedge clk);
        drv_i(2'b10, 32'h400, 1'b0, 1'b0, 6'h15);
        drv_d(2'b10, 32'h500, 1'b1, 1'b0, 6'h01);
        #1;
        check("coll_d_addr", m_haddr, 32'h500);
        check("coll_d_write", 32'(m_hwrite), 1);
        check("coll_i_rdy0", 32'(i_hready), 1);
        @(negedge clk);
        drv_i(2'b00, 32'h0, 1'b0, 1'b0, 6'h0);
        drv_d(2'b00, 32'h0, 1'b0, 1'b0, 6'h0);
        d_hwdata = 32'hD0D0_0001; d_hwchk = 7'h2A;
        #1;
        check("coll_i_pend", 32'(i_hready), 0);
        check("coll_buf_addr", m_haddr, 32'h400);
        check("coll_buf_htrans", 32'(m_htrans), 2);
        check("coll_buf_parity", 32'(m_hpar), 32'h15);
        check("coll_buf_write", 32'(m_hwrite), 0);
        check("coll_owner_d", 32'(owner), 2);
        check("coll_hwdata", m_hwdata, 32'hD0D0_0001);
        check("coll_hwchk", 32'(m_hwchk), 32'h2A);
        @(negedge clk);
        d_hwdata = '0; d_hwchk = '0;
        #1;
        check("coll_owner_i", 32'(owner), 1);
        check("coll_i_rdy2", 32'(i_hready), 1);
        check("coll_idle", 32'(m_htrans), 0);
        @(negedge clk); #1;
        check("coll_owner_end", 32'(owner), 0);

        // Anti-starvation: the buffered instruction request stalls data exactly once
        stalls = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            drv_d((st_d_addr[c] != 0) ? 2'b10 : 2'b00, st_d_addr[c], 1'b0, 1'b0, 6'h0);
            drv_i((st_i_addr[c] != 0) ? 2'b10 : 2'b00, st_i_addr[c], 1'b0, 1'b0, 6'h0);
            #1;
            check($sformatf("starve_addr%0d", c), m_haddr, st_m_addr[c]);
            check($sformatf("starve_trans%0d", c), 32'(m_htrans), (st_m_addr[c] != 0) ? 2 : 0);
            check($sformatf("starve_drdy%0d", c), 32'(d_hready), 32'(st_d_rdy[c]));
            check($sformatf("starve_irdy%0d", c), 32'(i_hready), 32'(st_i_rdy[c]));
            check($sformatf("starve_owner%0d", c), 32'(owner), 32'(st_owner[c]));
            if (!d_hready) stalls++;
        end
        check("starve_stalls", 32'(stalls), 1);
        @(negedge clk);
        drv_d(2'b00, 32'h0, 1'b0, 1'b0, 6'h0);
        #1;
        check("starve_owner_end", 32'(owner), 0);

        // Locked read-modify-write on data; instruction waits for the lock release
        @(negedge clk);
        drv_d(2'b10, 32'h200, 1'b0, 1'b1, 6'h0);
        #1;
        check("lock_rd_addr", m_haddr, 32'h200);
        check("lock_rd_lock", 32'(m_hlock), 1);
        @(negedge clk);
        drv_d(2'b10, 32'h200, 1'b1, 1'b1, 6'h0);
        drv_i(2'b10, 32'h300, 1'b0, 1'b0, 6'h0);
        #1;
        check("lock_wr_addr", m_haddr, 32'h200);
        check("lock_wr_write", 32'(m_hwrite), 1);
        check("lock_wr_lock", 32'(m_hlock), 1);
        check("lock_i_rdy0", 32'(i_hready), 1);
        @(negedge clk);
        drv_d(2'b00, 32'h0, 1'b0, 1'b0, 6'h0);
        drv_i(2'b00, 32'h0, 1'b0, 1'b0, 6'h0);
        d_hwdata = 32'h0000_BEEF;
        #1;
        check("lock_i_pend", 32'(i_hready), 0);
        check("lock_no_grant", 32'(m_htrans), 0);
        check("lock_owner_d", 32'(owner), 2);
        @(negedge clk);
        d_hwdata = '0;
        #1;
        check("lock_rel_addr", m_haddr, 32'h300);
        check("lock_rel_trans", 32'(m_htrans), 2);
        check("lock_rel_lock", 32'(m_hlock), 0);
        check("lock_rel_i_pend", 32'(i_hready), 0);
        @(negedge clk); #1;
        check("lock_i_rdy", 32'(i_hready), 1);
        check("lock_owner_i", 32'(owner), 1);
        @(negedge clk); #1;
        check("lock_owner_end", 32'(owner), 0);

        // Data write with two wait states then a two-cycle ERROR
        @(negedge clk);
        drv_d(2'b10, 32'h600, 1'b1, 1'b0, 6'h0);
        #1;
        check("err_addr", m_haddr, 32'h600);
        @(negedge clk);
        drv_d(2'b00, 32'h0, 1'b0, 1'b0, 6'h0);
        d_hwdata = 32'h1234_5678; d_hwchk = 7'h55;
        drv_i(2'b10, 32'h700, 1'b0, 1'b0, 6'h0B);
        m_hready = 1'b0;
        #1;
        check("err_w1_chk", 32'(m_hwchk), 32'h55);
        check("err_w1_data", m_hwdata, 32'h1234_5678);
        check("err_w1_drdy", 32'(d_hready), 0);
        check("err_w1_irdy", 32'(i_hready), 1);
        check("err_w1_dresp", 32'(d_hresp), 0);
        @(negedge clk);
        drv_i(2'b00, 32'h0, 1'b0, 1'b0, 6'h0);
        #1;
        check("err_w2_chk", 32'(m_hwchk), 32'h55);
        check("err_w2_i_pend", 32'(i_hready), 0);
        check("err_w2_drdy", 32'(d_hready), 0);
        @(negedge clk);
        m_hresp = 1'b1;
        #1;
        check("err_e1_dresp", 32'(d_hresp), 1);
        check("err_e1_iresp", 32'(i_hresp), 0);
        check("err_e1_chk", 32'(m_hwchk), 32'h55);
        check("err_e1_drdy", 32'(d_hready), 0);
        @(negedge clk);
        m_hready = 1'b1;
        #1;
        check("err_e2_dresp", 32'(d_hresp), 1);
        check("err_e2_iresp", 32'(i_hresp), 0);
        check("err_e2_drdy", 32'(d_hready), 1);
        check("err_e2_chk", 32'(m_hwchk), 32'h55);
        check("err_e2_i_addr", m_haddr, 32'h700);
        check("err_e2_i_par", 32'(m_hpar), 32'h0B);
        @(negedge clk);
        m_hresp = 1'b0; d_hwdata = '0; d_hwchk = '0;
        #1;
        check("err_owner_i", 32'(owner), 1);
        check("err_dresp_end", 32'(d_hresp), 0);
        check("err_i_rdy", 32'(i_hready), 1);
        @(negedge clk); #1;
        check("err_owner_end", 32'(owner), 0);

        // Reset while instruction is pending and data is in its data phase
        @(negedge clk);
        drv_i(2'b10, 32'h900, 1'b0, 1'b0, 6'h3);
        drv_d(2'b10, 32'hA00, 1'b1, 1'b0, 6'h4);
        #1;
        check("rst2_d_addr", m_haddr, 32'hA00);
        @(negedge clk);
        drv_i(2'b00, 32'h0, 1'b0, 1'b0, 6'h0);
        drv_d(2'b00, 32'h0, 1'b0, 1'b0, 6'h0);
        d_hwdata = 32'hAAAA_5555; d_hwchk = 7'h7F;
        resetn = 1'b0; m_hresp = 1'b1;
        #1;
        check("rst2_i_pend", 32'(i_hready), 0);
        @(negedge clk); #1;
        check("rst2_htrans", 32'(m_htrans), 0);
        check("rst2_haddr", m_haddr, 0);
        check("rst2_hwrite", 32'(m_hwrite), 0);
        check("rst2_hwdata", m_hwdata, 0);
        check("rst2_hwchk", 32'(m_hwchk), 0);
        check("rst2_i_rdy", 32'(i_hready), 1);
        check("rst2_d_rdy", 32'(d_hready), 1);
        check("rst2_i_resp", 32'(i_hresp), 0);
        check("rst2_d_resp", 32'(d_hresp), 0);
        check("rst2_owner", 32'(owner), 0);
        @(negedge clk);
        resetn = 1'b1; m_hresp = 1'b0; d_hwdata = '0; d_hwchk = '0;
        #1;
        check("rst2_no_replay", 32'(m_htrans), 0);
        check("rst2_i_rdy_after", 32'(i_hready), 1);
        @(negedge clk); #1;
        check("rst2_owner_after", 32'(owner), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ahb_dual_arbiter.md
# ahb_dual_arbiter

Two-master AHB-Lite arbiter that merges the core's instruction and data buses onto a single AHB-Lite slave port, for single-ported memory subsystems behind `system_core`. Each master has a one-entry address-phase holding stage, so a transfer that loses arbitration is captured and replayed later without violating AHB-Lite. The custom protection signals (checksum, parity) are routed with the data and address they cover.

## Interface
Parameters:
- `DATA_PRIO`, default 1: 1 gives fixed priority of data over instruction among live requests; 0 gives instruction priority.

Ports (name, direction, width, meaning). Signals listed as `s_x_*` exist once per master: `x = i` (instruction), `x = d` (data).
- `s_clk_i`  in  1  clock
- `s_resetn_i`  in  1  reset, synchronous, active-low
- `s_x_haddr_i`, `s_x_hwdata_i`  in  32  master address, write data
- `s_x_htrans_i`  in  2  transfer type
- `s_x_hsize_i`, `s_x_hburst_i`  in  3  size, burst
- `s_x_hprot_i`  in  4  protection
- `s_x_hwrite_i`, `s_x_hmastlock_i`  in  1  write, lock
- `s_x_hwchecksum_i`  in  7  write-data checksum
- `s_x_hparity_i`  in  6  address-phase parity
- `s_x_hrdata_o`  out  32  read data
- `s_x_hrchecksum_o`  out  7  read-data checksum
- `s_x_hready_o`, `s_x_hresp_o`  out  1  ready, error response to the master
- `s_m_haddr_o`, `s_m_hwdata_o`  out  32  slave address, write data
- `s_m_htrans_o`, `s_m_hsize_o`, `s_m_hburst_o`, `s_m_hprot_o`, `s_m_hwrite_o`, `s_m_hmastlock_o`, `s_m_hwchecksum_o`, `s_m_hparity_o`  out  widths as the master inputs: slave request signals
- `s_m_hrdata_i` (32), `s_m_hrchecksum_i` (7), `s_m_hready_i` (1), `s_m_hresp_i` (1)  in: slave response
- `s_owner_o`  out  2  data-phase owner: 0 = none, 1 = instruction, 2 = data

## Operation
Per-master input stage, with states IDLE, PEND and DATA:
- IDLE to PEND: the master presents `htrans[1] = 1`, its `hready_o = 1`, and it is not granted the slave address phase this cycle. All address-phase signals, including parity, are captured in the buffer.
- IDLE or PEND to DATA: the master's live or buffered request is granted while `s_m_hready_i = 1`.
- DATA to IDLE: `s_m_hready_i = 1`. If the master is granted a new live request in that same cycle, it stays in DATA instead.

Arbitration takes place only in cycles where `s_m_hready_i = 1`:
1. A locked sequence goes first. If the owner of the last granted address phase had `hmastlock = 1`, only that master is eligible.
2. A buffered (PEND) request beats any live request. This is the anti-starvation rule.
3. Between two live requests, `DATA_PRIO` decides.
4. With no request, drive `s_m_htrans_o = 0` and all other slave address-phase outputs to 0.

Routing:
- Slave address-phase outputs come from the granted source: the live inputs or the buffer.
- `s_m_hwdata_o` and `s_m_hwchecksum_o` are muxed by the data-phase owner. The owner register is loaded from the grant when `s_m_hready_i = 1`.
- `hrdata` and `hrchecksum` are broadcast to both masters.
- `hresp` goes only to the owner; the other master sees 0.

`s_x_hready_o` per state:
- IDLE: 1.
- PEND: 0.
- DATA: `s_m_hready_i`.

An ERROR response (two cycles, `hresp = 1`) is forwarded unchanged to the owner. No retry is performed.

## Timing
- Reset (synchronous, `s_resetn_i = 0` at a clock edge) puts the block in this state:
  - both stages IDLE, buffers cleared, owner = 0;
  - `s_m_htrans_o = 0` and all `s_m_*` outputs 0;
  - `s_x_hready_o = 1`, `s_x_hresp_o = 0`;
  - `s_owner_o = 0`.
- Reset during a transfer discards the in-flight and buffered transfers. No completion is issued.
- Latency:
  - A granted live request reaches the slave combinationally, adding 0 cycles.
  - A buffered request adds at least 1 cycle, plus the remaining data phase of the other master.
- Simultaneous live requests in a ready cycle: the winner goes to the slave and the loser enters PEND. The loser is granted at the next ready cycle, even if the winner issues again.
- Slave wait states (`s_m_hready_i = 0`): grant, owner and buffers hold. A master in IDLE may still be captured into PEND during such a cycle.
- A buffer is one entry deep. A master in PEND sees `hready = 0`, so it cannot issue a second request and the buffer cannot overflow.

## Test plan
- Single master: D reads `0x100` while I is idle, slave has 0 wait states. Expect `s_m_haddr_o = 0x100` in the same cycle, `s_d_hrdata_o` = slave data one cycle later, and `s_i_hready_o = 1` throughout.
- Collision with `DATA_PRIO = 1`: I and D issue at cycle N. Expect D on the slave at N, I in PEND with `s_i_hready_o = 0`, I's buffered address on the slave at N+1, and `s_owner_o` = 2 then 1.
- Anti-starvation: D issues back-to-back for 8 cycles while I issues once. Expect I granted at the first slave-ready cycle after it is captured, so D is stalled exactly once.
- Lock: D does a locked read-modify-write at `0x200` while I requests during the sequence. Expect I to stay in PEND until D's lock is released.
- Error and wait states: the slave inserts 2 wait states and then ERROR on a D write. Expect `s_d_hresp_o` high for 2 cycles, `s_i_hresp_o = 0`, and `s_m_hwchecksum_o` equal to D's checksum throughout the data phase.
- Reset mid-transfer: assert `s_resetn_i = 0` while I is in PEND and D is in DATA. At the next clock edge, expect every output at its reset value.
